aes_ctr_stream_ctrl: RTL



---
 rtl/aes_pkg.sv | 26 ++
 rtl/aes_ctr_stream_ctrl_fifo.sv | 57 +++++
 rtl/aes_ctr_stream_ctrl.sv | 130 +++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared types and constants for the AES counter-mode stream controller.
// Delay-stage bundle and the counter increment helper live here.
package aes_pkg;

   localparam int AES_BLK = 128;
   localparam int AES_NR  = 10;
   localparam int LAT     = AES_NR + 1;

   typedef struct packed {
      logic               valid;
      logic [AES_BLK-1:0] data;
      logic               last;
   } dly_t;

   // Only the low w bits count; the upper field never sees a carry.
   function automatic logic [AES_BLK-1:0] ctr_next(
      input logic [AES_BLK-1:0] c,
      input int                 w
   );
      logic [AES_BLK-1:0] m;
      m = (w >= AES_BLK) ? '1 :
          ((AES_BLK'(1) << w) - AES_BLK'(1));
      return (c & ~m) | ((c + AES_BLK'(1)) & m);
   endfunction

endpackage

// File: rtl/aes_ctr_stream_ctrl_fifo.sv
// Synchronous first-word-fall-through FIFO used as the result buffer.
// Head word is presented combinationally from the read pointer.
module sync_fifo #(
   parameter int W     = 129,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en,
   input  logic [W-1:0]             wr_data,
   input  logic                     rd_en,
   output logic [W-1:0]             rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wp;
   logic [AW-1:0] rp;
   logic          do_wr;
   logic          do_rd;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_wr   = wr_en && !full;
   assign do_rd   = rd_en && !empty;
   assign rd_data = mem[rp];

   always_ff @(posedge clk) begin
      if (rst) begin
         wp    <= '0;
         rp    <= '0;
         count <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (do_wr) begin
            mem[wp] <= wr_data;
            wp      <= wp + AW'(1);
         end
         if (do_rd) begin
            rp <= rp + AW'(1);
         end
         unique case ({do_wr, do_rd})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/aes_ctr_stream_ctrl.sv
// CTR-mode front/back end for a fixed-latency, non-stalling AES pipeline.
// Credits cover delay line plus FIFO so a returned keystream is never dropped.
module aes_ctr_stream_ctrl
   import aes_pkg::*;
#(
   parameter int Nr         = LAT - 1,
   parameter int CTR_W      = 32,
   parameter int FIFO_DEPTH = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [AES_BLK-1:0] iv,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [AES_BLK-1:0] in_data,
   input  logic               in_last,
   output logic [AES_BLK-1:0] enc_in,
   input  logic [AES_BLK-1:0] enc_out,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [AES_BLK-1:0] out_data,
   output logic               out_last,
   output logic               busy
);

   localparam int DLY = Nr + 1;
   localparam int CRW = 16;
   localparam int FCW = $clog2(FIFO_DEPTH) + 1;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN
   } state_t;

   state_t             state;
   state_t             state_nx;
   logic [AES_BLK-1:0] ctr;
   dly_t               dly [DLY];
   dly_t               wb;
   logic [CRW-1:0]     credits;
   logic               dly_busy;
   logic               accept;
   logic               pop;
   logic               fifo_full;
   logic               fifo_empty;
   logic [FCW-1:0]     fifo_count;
   logic [AES_BLK:0]   fifo_rd;

   assign accept    = in_valid && in_ready;
   assign pop       = out_valid && out_ready;
   assign in_ready  = (state == RUN) && (credits < CRW'(FIFO_DEPTH));
   assign enc_in    = ctr;
   assign busy      = (state != IDLE);
   assign out_valid = !fifo_empty;
   assign out_data  = fifo_rd[AES_BLK-1:0];
   assign out_last  = fifo_rd[AES_BLK];

   always_comb begin
      dly_busy = wb.valid;
      credits  = CRW'(wb.valid) + CRW'(fifo_count);
      for (int i = 0; i < DLY; i++) begin
         dly_busy = dly_busy | dly[i].valid;
         credits  = credits + CRW'(dly[i].valid);
      end
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (start) state_nx = RUN;
         RUN:     if (accept && in_last) state_nx = DRAIN;
         DRAIN:   if (!dly_busy && fifo_empty) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         ctr   <= '0;
         wb    <= '0;
         for (int i = 0; i < DLY; i++) begin
            dly[i] <= '0;
         end
      end else begin
         state <= state_nx;
         if (state == IDLE && start) begin
            ctr <= iv;
         end else if (accept) begin
            ctr <= ctr_next(ctr, CTR_W);
         end
         if (accept) begin
            dly[0] <= '{valid: 1'b1, data: in_data, last: in_last};
         end else begin
            dly[0] <= '0;
         end
         for (int i = 1; i < DLY; i++) begin
            dly[i] <= dly[i-1];
         end
         // Last stage lines up with the pipeline output register.
         wb.valid <= dly[DLY-1].valid;
         wb.data  <= dly[DLY-1].data ^ enc_out;
         wb.last  <= dly[DLY-1].last;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         assert (!(wb.valid && fifo_full));
      end
   end

   sync_fifo #(
      .W     (AES_BLK + 1),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wb.valid),
      .wr_data ({wb.last, wb.data}),
      .rd_en   (pop),
      .rd_data (fifo_rd),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

endmodule
